// File: rtl/srmem_drain.sv
// Drains a double-buffered srmem one entry at a time, serializing valid slots onto a ready/valid stream.
// Optional word counter: define SRMEM_DRAIN_CNT_EN to enable word_cnt; otherwise it is tied to 0.
module srmem_drain #(
    parameter int NUM_RDPORT = 1,
    parameter int DATA_BW    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_RDPORT*(DATA_BW+1)-1:0]   dout_list,
    input  logic                                rdvalid,
    input  logic                                rdlastinfo,
    output logic                                req_pop,
    output logic                                req_newdata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_BW-1:0]                  out_data,
    output logic                                out_last,
    output logic                                frame_done,
    output logic [15:0]                         word_cnt
);

    // state | meaning
    // IDLE  | waiting for a valid head entry, snapshot taken on rdvalid
    // SCAN  | walking snapshot slots, emitting valid ones
    // POP   | req_pop pulse for the drained entry
    // NEXT  | req_newdata / frame_done pulse after the last entry of a frame

    localparam int SLOT_W = DATA_BW + 1;
    localparam int LIST_W = NUM_RDPORT * SLOT_W;
    localparam int IDX_W  = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RDPORT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, POP, NEXT} state_t;

    state_t              state;
    logic [LIST_W-1:0]   snap;
    logic                last_q;
    logic [IDX_W-1:0]    idx;
    logic [DATA_BW+1:0]  view_first;
    logic [DATA_BW+1:0]  view_next;

    // Returns {last, valid, data} for slot sel; last uses the highest valid slot of the entry.
    function automatic logic [DATA_BW+1:0] slot_view(input logic [LIST_W-1:0] list,
                                                     input int sel, input logic is_last);
        int                 hi;
        logic               vld;
        logic [DATA_BW-1:0] dat;
        hi = 0;
        for (int j = 0; j < NUM_RDPORT; j++) begin
            if (list[j*SLOT_W + DATA_BW]) hi = j;
        end
        vld = list[sel*SLOT_W + DATA_BW];
        dat = vld ? list[sel*SLOT_W +: DATA_BW] : '0;
        return {is_last && vld && (hi == sel), vld, dat};
    endfunction

    always_comb begin
        view_first = slot_view(dout_list, 0, rdlastinfo);
        view_next  = '0;
        if (idx != IDX_LAST) view_next = slot_view(snap, int'(idx) + 1, last_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            snap        <= '0;
            last_q      <= 1'b0;
            idx         <= '0;
            req_pop     <= 1'b0;
            req_newdata <= 1'b0;
            frame_done  <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
        end else begin
            req_pop     <= 1'b0;
            req_newdata <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdvalid) begin
                        snap   <= dout_list;
                        last_q <= rdlastinfo;
                        idx    <= '0;
                        state  <= SCAN;
                        {out_last, out_valid, out_data} <= view_first;
                    end
                end
                SCAN: begin
                    // Invalid slots skip after one cycle; valid slots wait for out_ready.
                    if (!out_valid || out_ready) begin
                        if (idx == IDX_LAST) begin
                            state     <= POP;
                            req_pop   <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            {out_last, out_valid, out_data} <= view_next;
                        end
                    end
                end
                POP: begin
                    if (last_q) begin
                        state       <= NEXT;
                        req_newdata <= 1'b1;
                        frame_done  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                NEXT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRMEM_DRAIN_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt <= 16'd0;
        end else if (state == NEXT) begin
            word_cnt <= 16'd0;
        end else if (state == SCAN && out_valid && out_ready && word_cnt != 16'hFFFF) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`else
    assign word_cnt = 16'd0;
`endif

endmodule

// File: doc/srmem_drain.md
SRMEM_DRAIN -- requirements
Module: srmem_drain

Interface
REQ-001 SHALL have parameter NUM_RDPORT, default 1, number of read slots per srmem entry.
REQ-002 SHALL have parameter DATA_BW, default 8, data bits per slot; each slot is DATA_BW+1 bits, with bit DATA_BW the slot-valid flag and bits DATA_BW-1:0 the data; slot 0 occupies the LSBs.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port dout_list  input  NUM_RDPORT*(DATA_BW+1)  current head entry of the upstream double-buffered srmem.
REQ-006 SHALL have port rdvalid  input  1  head entry is valid.
REQ-007 SHALL have port rdlastinfo  input  1  head entry is the last entry of the current frame.
REQ-008 SHALL have port req_pop  output  1  one-cycle pulse that pops the head entry.
REQ-009 SHALL have port req_newdata  output  1  one-cycle pulse that releases the drained buffer and requests the next frame.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word when out_valid is also high.
REQ-012 SHALL have port out_data  output  DATA_BW  serialized slot data.
REQ-013 SHALL have port out_last  output  1  marks the final valid slot of a frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a frame is fully drained.
REQ-015 SHALL have port word_cnt  output  16  words emitted in the current frame (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, POP and NEXT.
REQ-017 In IDLE with rdvalid=1, SHALL latch dout_list into a snapshot and rdlastinfo into last_q, set slot index idx=0, and go to SCAN; with rdvalid=0, SHALL stay in IDLE.
REQ-018 In SCAN, when the snapshot slot idx has valid=1, SHALL drive out_valid=1 with out_data equal to that slot's data, and SHALL advance idx only in a cycle where out_ready=1.
REQ-019 In SCAN, when slot idx has valid=0, SHALL keep out_valid=0 and advance idx after one cycle.
REQ-020 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_last=1 only when last_q=1 and idx equals the highest valid slot index of the snapshot, computed by priority encoder.
REQ-022 When idx=NUM_RDPORT-1 completes (accepted or skipped), SHALL go to POP.
REQ-023 In POP, SHALL assert req_pop for exactly one cycle, then go to NEXT if last_q=1, else to IDLE.
REQ-024 In NEXT, SHALL assert req_newdata and frame_done for exactly one cycle, then go to IDLE.
REQ-025 Latency: with rdvalid sampled in IDLE at cycle t and slot 0 valid, out_valid SHALL be 1 at t+1.
REQ-026 Latency: with NUM_RDPORT=1 and out_ready=1, req_pop SHALL be 1 at t+2; if last, req_newdata SHALL be 1 at t+3.
REQ-027 SHALL ignore rdvalid, dout_list and rdlastinfo outside IDLE, because all decisions use the snapshot.
REQ-028 An entry with no valid slots SHALL still be popped; if it is last, frame_done SHALL pulse with no out_last in that entry.
REQ-029 SHALL never assert req_pop and req_newdata in the same cycle, and never assert either while out_valid=1.

Reset
REQ-030 While rst=0 at a clock edge, SHALL enter IDLE, clear the snapshot, last_q, idx and word_cnt, and drive req_pop, req_newdata, out_valid, out_last and frame_done to 0 and out_data to 0.
REQ-031 A reset asserted mid-frame SHALL discard the pending entry without issuing req_pop or req_newdata.

Configuration
REQ-032 With macro SRMEM_DRAIN_CNT_EN defined, word_cnt SHALL increment on each accepted word, saturate at 16'hFFFF, and clear in the cycle after frame_done.
REQ-033 Without SRMEM_DRAIN_CNT_EN, word_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-034 Scenario: NUM_RDPORT=1, DATA_BW=8, slot={1,8'hA5}, rdlastinfo=1, out_ready=1 -> out_data=A5 with out_last=1 at t+1, req_pop at t+2, req_newdata and frame_done at t+3.
REQ-035 Scenario: NUM_RDPORT=4, slots valid pattern 1,0,1,0 with data 11,22,33,44, last=1 -> outputs 11 then 33, out_last only on 33, one req_pop.
REQ-036 Scenario: out_ready held 0 for 5 cycles on first word -> out_valid and out_data=11 stay constant for those 5 cycles, no req_pop.
REQ-037 Scenario: three non-last entries followed by one last entry -> three req_pop pulses with no req_newdata, then on the last entry one req_pop followed by one req_newdata; with SRMEM_DRAIN_CNT_EN defined, word_cnt equals the total accepted words before clearing.
REQ-038 Scenario: rst=0 asserted during SCAN -> the next cycle is IDLE with all outputs 0, and no req_pop is issued for that entry.
REQ-039 Scenario: last entry with all slots invalid -> no out_valid, req_pop, then frame_done.
